// File: rtl/lvds_rx_deser_pkg.sv
// -----------------------------------------------------------------------------
// lvds_pkg
// Shared types and constants for the LVDS receive deserializer.
//   lvds_rx_state_t : word-alignment FSM states (HUNT, VERIFY, LOCKED)
//   LVDS_K285_RDN   : K28.5 comma word, running disparity minus, MSB first
//   LVDS_ERR_CNT_W  : width of the sync-loss event counter
// -----------------------------------------------------------------------------
package lvds_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lvds_rx_state_t;

  localparam logic [9:0] LVDS_K285_RDN  = 10'b0011111010;
  localparam int         LVDS_ERR_CNT_W = 16;

endpackage

// File: rtl/lvds_rx_deser_if.sv
// -----------------------------------------------------------------------------
// lvds_rx_deser_if
// Pad pair plus parallel receive-side outputs of the LVDS deserializer.
//   i_p, i_n   : differential pad pair (true / complement)
//   dout       : received word, MSB = first bit received
//   dout_vld   : one-cycle strobe, dout valid
//   locked     : word alignment established
//   err_cnt    : sync-loss event counter
//   dbg_state  : current alignment FSM state (observation only)
// Handshake: dout_vld is a push-only strobe with no ready/back-pressure; the
// consumer must take dout in the cycle dout_vld is high. dout holds its value
// between strobes.
// Modports: master = pad driver / word consumer, slave = deserializer.
// -----------------------------------------------------------------------------
interface lvds_rx_deser_if #(
  parameter int W = 10
);
  import lvds_pkg::*;

  logic                      i_p;
  logic                      i_n;
  logic [W-1:0]              dout;
  logic                      dout_vld;
  logic                      locked;
  logic [LVDS_ERR_CNT_W-1:0] err_cnt;
  lvds_rx_state_t            dbg_state;

  modport master (
    output i_p, i_n,
    input  dout, dout_vld, locked, err_cnt, dbg_state
  );

  modport slave (
    input  i_p, i_n,
    output dout, dout_vld, locked, err_cnt, dbg_state
  );

endinterface

// File: rtl/lvds_rx_deser_ilvds.sv
// -----------------------------------------------------------------------------
// fpga_ilvds
// True-LVDS input buffer. The only technology-specific part of the receiver.
//   i_p : pad, true side
//   i_n : pad, complement side
//   o   : single-ended received bit, to the sampling register
// Macro FPGA_GOWIN selects the GoWin TLVDS_IBUF primitive; otherwise a
// behavioural differential comparator is used (equal legs read as 0).
// -----------------------------------------------------------------------------
module fpga_ilvds (
  input  logic i_p,
  input  logic i_n,
  output logic o
);

`ifdef FPGA_GOWIN
  TLVDS_IBUF u_tlvds_ibuf (
    .I  (i_p),
    .IB (i_n),
    .O  (o)
  );
`else
  assign o = i_p & ~i_n;
`endif

endmodule

// File: rtl/lvds_rx_deser.sv
// -----------------------------------------------------------------------------
// lvds_rx_deser
// Serial LVDS receive deserializer. Samples one bit per clk, hunts for the
// SYNC comma, qualifies lock over LOCK_CNT consecutive aligned SYNC words and
// then delivers aligned parallel words with a one-cycle valid strobe.
// Ports:
//   clk : link bit clock (only clock)
//   rst : asynchronous, active-high reset
//   bus : lvds_rx_deser_if.slave (pads in, dout/dout_vld/locked/err_cnt out)
// Optional feature macro LVDS_RX_ERR_CNT_EN: when defined, err_cnt is a 16-bit
// saturating count of VERIFY->HUNT rejections and LOCKED->HUNT losses;
// otherwise err_cnt is tied to 0.
// -----------------------------------------------------------------------------
module lvds_rx_deser
  import lvds_pkg::*;
#(
  parameter int             W        = 10,
  parameter logic [W-1:0]   SYNC     = W'(LVDS_K285_RDN),
  parameter int             LOCK_CNT = 4,
  parameter int             MAX_GAP  = 256
) (
  input  logic              clk,
  input  logic              rst,
  lvds_rx_deser_if.slave    bus
);

  localparam int PW = $clog2(W);
  localparam int WW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int GW = $clog2(MAX_GAP + 1);

  localparam logic [PW-1:0] PH_LAST    = PW'(W - 1);
  localparam logic [WW-1:0] WORDS_LOCK = WW'(LOCK_CNT);
  localparam logic [GW-1:0] GAP_MAX    = GW'(MAX_GAP);

  logic           buf_o;
  logic           s_in_q;
  logic [W-1:0]   sr_q, sr_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [WW-1:0]  words_q, words_d;
  logic [GW-1:0]  gap_q, gap_d;
  lvds_rx_state_t state_q, state_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           vld_q, vld_d;
  logic           locked_q, locked_d;
  logic           sync_hit;
  logic           boundary;
  logic           loss_evt;

  fpga_ilvds u_ilvds (
    .i_p (bus.i_p),
    .i_n (bus.i_n),
    .o   (buf_o)
  );

  assign sync_hit = (sr_q == SYNC);
  assign boundary = (phase_q == PH_LAST);

  // Next-state / output decode. sr_q holds a complete word when boundary is
  // high; decisions land in the output registers one edge later.
  always_comb begin
    sr_d     = {sr_q[W-2:0], s_in_q};
    state_d  = state_q;
    phase_d  = boundary ? '0 : phase_q + PW'(1);
    words_d  = words_q;
    gap_d    = gap_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    loss_evt = 1'b0;

    case (state_q)
      HUNT: begin
        if (sync_hit) begin
          // Alignment candidate: the next word ends W samples from now.
          phase_d = '0;
          words_d = WW'(1);
          gap_d   = '0;
          state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end

      VERIFY: begin
        if (boundary) begin
          if (sync_hit) begin
            words_d = words_q + WW'(1);
            if (words_q + WW'(1) == WORDS_LOCK) begin
              state_d = LOCKED;
              gap_d   = '0;
            end
          end else begin
            state_d  = HUNT;
            loss_evt = 1'b1;
          end
        end
      end

      LOCKED: begin
        if (boundary) begin
          if (sync_hit) begin
            gap_d = '0;
          end else if (gap_q == GAP_MAX) begin
            // One data word too many since the last SYNC: drop it, re-hunt.
            state_d  = HUNT;
            loss_evt = 1'b1;
          end else begin
            dout_d = sr_q;
            vld_d  = 1'b1;
            gap_d  = gap_q + GW'(1);
          end
        end
      end

      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_in_q   <= 1'b0;
      sr_q     <= '0;
      phase_q  <= '0;
      words_q  <= '0;
      gap_q    <= '0;
      state_q  <= HUNT;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      s_in_q   <= buf_o;
      sr_q     <= sr_d;
      phase_q  <= phase_d;
      words_q  <= words_d;
      gap_q    <= gap_d;
      state_q  <= state_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.locked    = locked_q;
  assign bus.dbg_state = state_q;

`ifdef LVDS_RX_ERR_CNT_EN
  logic [LVDS_ERR_CNT_W-1:0] err_q, err_d;

  // Saturating: sticks at all-ones until rst.
  always_comb begin
    err_d = err_q;
    if (loss_evt && (err_q != '1)) begin
      err_d = err_q + LVDS_ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_cnt = err_q;
`else
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
  assign bus.err_cnt     = '0;
`endif

endmodule

// File: tb/tb_lvds_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_lvds_rx_deser
// Self-checking bench for lvds_rx_deser. Each scenario builds a bit stream,
// derives the expected strobes / lock trace / error count from a stream-level
// reference model, then drives the pad and compares every cycle.
// -----------------------------------------------------------------------------
module tb_lvds_rx_deser;
  import lvds_pkg::*;

  localparam int W        = 10;
  localparam int LOCK_CNT = 4;
  localparam int MAX_GAP  = 256;
  localparam int NMAX     = 4096;
  localparam logic [W-1:0] SYNC = 10'b0011111010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvds_rx_deser_if #(.W(W)) bus ();

  lvds_rx_deser #(
    .W        (W),
    .SYNC     (SYNC),
    .LOCK_CNT (LOCK_CNT),
    .MAX_GAP  (MAX_GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- stream + model storage ----------------
  logic         bits [NMAX];
  int           nb;
  logic         exp_vld  [NMAX + 2];
  logic         exp_lock [NMAX + 2];
  logic [W-1:0] exp_q [$];
  int           m_err;

  int   n_checks = 0;
  int   n_err    = 0;
  int   obs_strobes;
  int   st_e [$];
  int   first_lock_e;
  int   fall_e;
  logic ever_locked;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- stream builders ----------------
  task automatic new_stream();
    nb = 0;
  endtask

  task automatic push_bit(input logic b);
    bits[nb] = b;
    nb++;
  endtask

  task automatic push_word(input logic [W-1:0] v);
    for (int j = W - 1; j >= 0; j--) push_bit(v[j]);
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] v;
    do v = W'($urandom_range(0, (1 << W) - 1)); while (v == SYNC);
    return v;
  endfunction

  // Last W bits on the wire up to and including bit t (zeros before start).
  function automatic logic [W-1:0] window(input int t);
    logic [W-1:0] w;
    w = '0;
    for (int j = 0; j < W; j++) begin
      int idx;
      idx = t - W + 1 + j;
      w = {w[W-2:0], (idx >= 0) ? bits[idx] : 1'b0};
    end
    return w;
  endfunction

  // ---------------- reference model ----------------
  // Parses the stream: hunt for SYNC anywhere, then examine every W-th
  // window after it. A decision on the window ending at bit t shows on the
  // outputs after sampling edge t+2.
  task automatic build_model(input int n);
    int           mode;   // 0 hunting, 1 verifying, 2 locked
    int           cnt;
    int           bnd;
    int           gap;
    logic [W-1:0] w;
    mode = 0; cnt = 0; bnd = 0; gap = 0; m_err = 0;
    exp_q.delete();
    for (int e = 0; e < n + 2; e++) begin
      exp_vld[e]  = 1'b0;
      exp_lock[e] = 1'b0;
    end
    for (int t = 0; t < n; t++) begin
      w = window(t);
      if (mode == 0) begin
        if (w == SYNC) begin
          cnt = 1; bnd = t + W; gap = 0;
          mode = (LOCK_CNT == 1) ? 2 : 1;
        end
      end else if (t == bnd) begin
        bnd = bnd + W;
        if (mode == 1) begin
          if (w == SYNC) begin
            cnt++;
            if (cnt == LOCK_CNT) mode = 2;
          end else begin
            mode = 0;
            m_err++;
          end
        end else begin
          if (w == SYNC) begin
            gap = 0;
          end else if (gap == MAX_GAP) begin
            mode = 0;
            m_err++;
          end else begin
            gap++;
            exp_vld[t + 2] = 1'b1;
            exp_q.push_back(w);
          end
        end
      end
      exp_lock[t + 2] = (mode == 2);
    end
  endtask

  function automatic int exp_err_cnt(input int events);
`ifdef LVDS_RX_ERR_CNT_EN
    return (events > 65535) ? 65535 : events;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_dout"},     bus.dout,     '0);
    chk({tag, "_dout_vld"}, bus.dout_vld, 1'b0);
    chk({tag, "_locked"},   bus.locked,   1'b0);
    chk({tag, "_err_cnt"},  bus.err_cnt,  '0);
    chk({tag, "_state"},    bus.dbg_state, HUNT);
  endtask

  // Holds rst with random pad activity; releases it on a falling edge so the
  // next rising edge samples bit 0 of the following segment.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.i_p = 1'($urandom_range(0, 1));
      bus.i_n = ~bus.i_p;
      @(posedge clk);
      @(negedge clk);
      check_idle("reset");
    end
    rst     = 1'b0;
    bus.i_p = 1'b0;
    bus.i_n = 1'b1;
  endtask

  task automatic run_segment(input int n);
    build_model(n);
    obs_strobes  = 0;
    st_e.delete();
    first_lock_e = -1;
    fall_e       = -1;
    ever_locked  = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.i_p = bits[k];
      bus.i_n = ~bits[k];
      @(posedge clk);
      @(negedge clk);
      chk("locked",   bus.locked,   exp_lock[k]);
      chk("dout_vld", bus.dout_vld, exp_vld[k]);
      if (bus.locked === 1'b1 && first_lock_e < 0) first_lock_e = k;
      if (ever_locked && bus.locked !== 1'b1 && fall_e < 0) fall_e = k;
      if (bus.locked === 1'b1) ever_locked = 1'b1;
      if (bus.dout_vld === 1'b1) begin
        obs_strobes++;
        st_e.push_back(k);
        if (exp_q.size() > 0) chk("dout", bus.dout, exp_q.pop_front());
      end
    end
    chk("words_not_delivered", exp_q.size(), 0);
    chk("err_cnt_end", bus.err_cnt, exp_err_cnt(m_err));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.i_p = 1'b0;
    bus.i_n = 1'b1;

    // Reset with random pad data, then a long idle pad: never locks.
    do_reset(20);
    new_stream();
    for (int i = 0; i < 1000; i++) push_bit(1'b0);
    run_segment(nb);
    chk("idle_never_locked", ever_locked, 1'b0);

    // Lock behind 3 junk bits, then one data word.
    do_reset(3);
    new_stream();
    for (int i = 0; i < 3; i++) push_bit(1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) push_word(SYNC);
    push_word(10'h155);
    push_word(SYNC);
    run_segment(nb);
    chk("lock_edge",    first_lock_e, 44);
    chk("strobe_count", obs_strobes,  1);
    chk("strobe_edge",  (st_e.size() > 0) ? st_e[0] : -1, 54);

    // SYNC between two data words is dropped: two strobes, 2W apart.
    do_reset(3);
    new_stream();
    for (int i = 0; i < 4; i++) push_word(SYNC);
    push_word(rand_data());
    push_word(SYNC);
    push_word(rand_data());
    push_word(SYNC);
    run_segment(nb);
    chk("drop_strobe_count", obs_strobes, 2);
    chk("drop_spacing", (st_e.size() == 2) ? st_e[1] - st_e[0] : -1, 2 * W);

    // Verify rejection after two SYNC words.
    do_reset(3);
    new_stream();
    for (int i = 0; i < 2; i++) push_word(SYNC);
    push_word(10'h2AA);
    for (int i = 0; i < 20; i++) push_bit(1'b0);
    run_segment(nb);
    chk("reject_never_locked", ever_locked, 1'b0);
    chk("reject_err_cnt", bus.err_cnt, exp_err_cnt(1));

    // Gap loss: 257 data words without SYNC.
    do_reset(3);
    new_stream();
    for (int i = 0; i < 4; i++) push_word(SYNC);
    for (int i = 0; i < MAX_GAP + 1; i++) push_word(rand_data());
    for (int i = 0; i < 20; i++) push_bit(1'b0);
    run_segment(nb);
    chk("gap_strobe_count", obs_strobes, MAX_GAP);
    chk("gap_loss_edge",    fall_e,      2611);

    // Reset pulse in the middle of data word 3, then relock.
    do_reset(3);
    new_stream();
    for (int i = 0; i < 4; i++) push_word(SYNC);
    for (int i = 0; i < 5; i++) push_word(rand_data());
    run_segment(4 * W + 2 * W + 4);
    chk("midword_strobes_before_reset", obs_strobes, 2);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    do_reset(3);
    new_stream();
    for (int i = 0; i < 4; i++) push_word(SYNC);
    for (int i = 0; i < 3; i++) push_word(rand_data());
    push_word(SYNC);
    run_segment(nb);
    chk("relock_strobe_count", obs_strobes, 3);
    chk("relock_edge", first_lock_e, 4 * W + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
